upsamp_hold: RTL and testbench
==============================

# upsamp_hold

Sample-rate expander feeding the output path: accepts decimated signed 12-bit samples through a strobe/busy handshake and emits each sample FACTOR times at the output tick rate (zero-order hold). It mirrors the decimator's producer interface: its `busy` output drives the upstream stage's busy input, and its `in_en` is driven by that stage's output strobe. A small FIFO absorbs bursty input. A sticky flag reports output starvation and another reports dropped input.

## Interface
- `FACTOR`, 10: output ticks per input sample (2..255).
- `DEPTH`, 4: input FIFO depth in samples (power of two, ≥2).
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous reset, active-low.
- `ena`  input  1  output-rate tick; may be held high continuously.
- `in_en`  input  1  input sample strobe, one sample per cycle high.
- `in_data`  input  12  signed input sample, valid with `in_en`.
- `busy`  output  1  FIFO full; upstream must not strobe `in_en`.
- `dataOut`  output  12  signed held sample, registered.
- `out_en`  output  1  one-cycle strobe, `dataOut` valid.
- `underrun`  output  1  sticky: a new sample was due and the FIFO was empty.
- `overflow`  output  1  sticky: `in_en` arrived while `busy` was high, so the sample was dropped.

## Operation
- Reset (`rst`=0 at an edge): FIFO emptied, state IDLE, phase=0, `dataOut`=0, `out_en`=0, `underrun`=0, `overflow`=0, hold register=0. `busy`=0 after reset.
- Reset mid-operation: discards FIFO contents and the hold value immediately. No partial repeat sequence completes.
- Push: when `in_en`=1 and `busy`=0, `in_data` is written and count increments. When `in_en`=1 and `busy`=1, the sample is dropped and `overflow` is set. The sample is dropped even if a pop occurs in the same cycle.
- Pop: happens only on `ena` when a new sample is due (see states). A push and a pop in the same cycle with count < DEPTH leave count unchanged. Write and read use separate pointers that wrap modulo DEPTH.
- `busy` = (count == DEPTH), derived from registers with no dependency on the current `in_en`.
- State IDLE (no sample ever held):
  - On `ena` with count>0: pop into the hold register, output it, phase←1, go to RUN.
  - On `ena` with count=0: no output; `underrun` stays unchanged.
- State RUN, on `ena`:
  - phase=0, count>0: pop, output the popped sample, phase←1.
  - phase=0, count=0: output the old hold value, set `underrun`, phase stays 0 so the next `ena` retries the pop.
  - phase≠0: output the hold value; phase←phase+1, wrapping to 0 after FACTOR-1.
- Without `ena`, all state holds and `out_en`=0.
- Widths: data is passed through unmodified, with no arithmetic. Phase counter is 8 bits.

## Timing
- `out_en` rises the cycle after the `ena` cycle that produced it and stays high for exactly one cycle, even when `ena` is continuous. `dataOut` changes only together with an `out_en` pulse.
- Input-to-output latency, from the first push into an empty IDLE block: the first `ena` at or after the cycle following the push pops the sample. `out_en` follows one cycle later.
- `busy` asserts the cycle after the push that fills the FIFO. It deasserts the cycle after a pop from full.
- Steady state with `ena` continuous: one pop every FACTOR cycles, so the sustained input rate is ≤ 1/FACTOR of the `ena` rate.

## Structure
- Shared package holds `SAMPLE_W`=12, the default `FACTOR`, and the IDLE/RUN state encoding. The decimator uses the same sample width.
- One sub-module, `sfifo_sync`: a synchronous FIFO parameterised by width and depth. It exposes push, pop, rd_data, count, full, empty, uses a synchronous active-low reset, and has a first-word-fall-through read.
- The top level contains the phase counter, the state register, the hold register, the output registers and the sticky flags.

## Test plan
All scenarios use FACTOR=10, DEPTH=4 unless stated otherwise.
- Reset check: drive `rst`=0 with `ena`=1 and `in_en`=1 -> `dataOut`=0, `out_en`=0, `busy`=0, both flags 0 throughout.
- Single sample: push 0x123, then hold `ena` high -> exactly 10 `out_en` pulses with `dataOut`=0x123, then `underrun`=1 and 0x123 keeps repeating.
- Sample sequence: push -5, 7, 2047, -2048 back-to-back, then hold `ena` high -> 10 pulses of each value in that order. `busy` is high for the cycles when count=4.
- Full and overflow: push 5 samples with `ena`=0 -> `busy`=1 after the 4th push, the 5th sample is dropped, `overflow`=1, and the output later shows only the first 4 samples.
- Sparse ticks: `ena` high 1 cycle in 3, input pushed at 1/30 of the clock rate -> no underrun, each value repeated exactly 10 times, and `out_en` always lands one cycle after an `ena` cycle.
- Reset mid-operation: reset during the 4th repeat of a sample while 2 samples are queued -> after release, outputs are silent until a new push, and the queued samples never appear.

Source files
------------

// File: rtl/upsamp_hold_pkg.sv
// Shared definitions for the sample-rate expander and its decimator peer.
// Holds the sample width, the default repeat factor and the IDLE/RUN state encoding.
package upsamp_hold_pkg;

    localparam int SAMPLE_W   = 12;
    localparam int FACTOR_DEF = 10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/upsamp_hold_sfifo_sync.sv
// Synchronous FIFO with first-word-fall-through read; push-to-visible latency 1 cycle.
// Backpressure: push ignored while full, pop ignored while empty; full/empty/count are registered.
module sfifo_sync #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/upsamp_hold.sv
// Zero-order-hold expander: each queued sample is emitted FACTOR times on ena ticks; out_en lags ena by 1 cycle.
// Backpressure: busy mirrors FIFO full; a strobe while busy is dropped and latches overflow.
module upsamp_hold
    import upsamp_hold_pkg::*;
#(
    parameter int FACTOR = FACTOR_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                in_en,
    input  logic signed [SAMPLE_W-1:0] in_data,
    output logic                busy,
    output logic signed [SAMPLE_W-1:0] dataOut,
    output logic                out_en,
    output logic                underrun,
    output logic                overflow
);

    localparam logic [7:0] LAST_PHASE = 8'(FACTOR - 1);

    sample_t                 rd_data;
    sample_t                 hold;
    logic [$clog2(DEPTH):0]  count;
    logic                    empty;
    logic                    pop;
    logic [0:0]              state;
    logic [7:0]              phase;

    // A new sample is due on the first tick ever, and on every tick that lands on phase 0.
    assign pop = ena && !empty && ((state == ST_IDLE) || (phase == 8'd0));

    sfifo_sync #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_en),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (rd_data),
        .count   (count),
        .full    (busy),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            phase    <= 8'd0;
            hold     <= '0;
            dataOut  <= '0;
            out_en   <= 1'b0;
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            out_en <= 1'b0;
            if (in_en && busy) overflow <= 1'b1;
            if (ena) begin
                if (state == ST_IDLE) begin
                    if (!empty) begin
                        hold    <= rd_data;
                        dataOut <= rd_data;
                        out_en  <= 1'b1;
                        phase   <= 8'd1;
                        state   <= ST_RUN;
                    end
                end else if (phase == 8'd0) begin
                    out_en <= 1'b1;
                    if (!empty) begin
                        hold    <= rd_data;
                        dataOut <= rd_data;
                        phase   <= 8'd1;
                    end else begin
                        // Starved: repeat the old value and retry the pop next tick.
                        dataOut  <= hold;
                        underrun <= 1'b1;
                    end
                end else begin
                    out_en  <= 1'b1;
                    dataOut <= hold;
                    phase   <= (phase == LAST_PHASE) ? 8'd0 : phase + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_upsamp_hold.sv
// Scoreboard bench for upsamp_hold: accepted pushes enqueue FACTOR expected copies, out_en pulses dequeue.
module tb_upsamp_hold;

    localparam int FACTOR = 10;
    localparam int DEPTH  = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               ena = 1'b0;
    logic               in_en = 1'b0;
    logic signed [11:0] in_data = '0;
    logic               busy;
    logic signed [11:0] dataOut;
    logic               out_en;
    logic               underrun;
    logic               overflow;

    int n_chk = 0;
    int n_err = 0;
    int exp_q[$];
    int last_exp = 0;
    int extra = 0;
    int pulses = 0;
    int base_extra;
    int base_pulses;

    upsamp_hold #(.FACTOR(FACTOR), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .in_en    (in_en),
        .in_data  (in_data),
        .busy     (busy),
        .dataOut  (dataOut),
        .out_en   (out_en),
        .underrun (underrun),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Output monitor: inputs captured at the rising edge, outputs checked on the falling edge.
    task automatic monitor();
        logic ena_s;
        logic rst_s;
        int   prev_dout = 0;
        int   exp;
        forever begin
            @(posedge clk);
            ena_s = ena;
            rst_s = rst;
            @(negedge clk);
            if (!rst_s) begin
                last_exp  = 0;
            end else if (out_en) begin
                pulses++;
                chk("out_en_after_ena", int'(ena_s), 1);
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    last_exp = exp;
                end else begin
                    exp = last_exp;
                    extra++;
                end
                chk("dataOut", int'(dataOut), exp);
            end else begin
                chk("dataOut_stable", int'(dataOut), prev_dout);
            end
            prev_dout = int'(dataOut);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        ena = 1'b1;
        in_en = 1'b1;
        in_data = 12'sh7FF;
        exp_q.delete();
        repeat (4) begin
            @(negedge clk);
            chk("rst_dataOut", int'(dataOut), 0);
            chk("rst_out_en", int'(out_en), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_underrun", int'(underrun), 0);
            chk("rst_overflow", int'(overflow), 0);
        end
        rst = 1'b1;
        ena = 1'b0;
        in_en = 1'b0;
    endtask

    task automatic push(input int v, input bit accept);
        @(negedge clk);
        in_en = 1'b1;
        in_data = 12'(v);
        if (accept) for (int k = 0; k < FACTOR; k++) exp_q.push_back(v);
    endtask

    task automatic idle();
        @(negedge clk);
        in_en = 1'b0;
    endtask

    task automatic run_ena(input int n);
        @(negedge clk);
        ena = 1'b1;
        repeat (n) @(negedge clk);
        ena = 1'b0;
    endtask

    task automatic mark();
        base_extra  = extra;
        base_pulses = pulses;
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset with ena and in_en active
        do_reset();
        @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);

        // Single sample
        mark();
        push(12'h123, 1'b1);
        idle();
        run_ena(13);
        repeat (2) @(negedge clk);
        chk("single_drained", exp_q.size(), 0);
        chk("single_pulses", pulses - base_pulses, 13);
        chk("single_repeats", extra - base_extra, 3);
        chk("single_underrun", int'(underrun), 1);
        chk("single_last", int'(dataOut), 12'h123);

        // Back-to-back sequence filling the FIFO
        do_reset();
        mark();
        push(-5, 1'b1);
        push(7, 1'b1);
        push(2047, 1'b1);
        chk("seq_busy_3", int'(busy), 0);
        push(-2048, 1'b1);
        idle();
        chk("seq_busy_4", int'(busy), 1);
        run_ena(45);
        repeat (2) @(negedge clk);
        chk("seq_busy_after", int'(busy), 0);
        chk("seq_drained", exp_q.size(), 0);
        chk("seq_repeats", extra - base_extra, 5);
        chk("seq_underrun", int'(underrun), 1);

        // Overflow: fifth push dropped
        do_reset();
        mark();
        push(100, 1'b1);
        push(200, 1'b1);
        push(300, 1'b1);
        push(400, 1'b1);
        push(500, 1'b0);
        chk("ovf_busy", int'(busy), 1);
        chk("ovf_flag_before", int'(overflow), 0);
        idle();
        chk("ovf_flag", int'(overflow), 1);
        run_ena(40);
        repeat (2) @(negedge clk);
        chk("ovf_drained", exp_q.size(), 0);
        chk("ovf_repeats", extra - base_extra, 0);
        chk("ovf_underrun", int'(underrun), 0);
        chk("ovf_sticky", int'(overflow), 1);

        // Sparse ticks: ena 1 in 3, input 1 in 30
        do_reset();
        mark();
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    push(k * 111 - 300, 1'b1);
                    idle();
                    repeat (28) @(negedge clk);
                end
            end
            begin
                repeat (2) @(negedge clk);
                for (int j = 0; j < 60; j++) begin
                    ena = 1'b1;
                    @(negedge clk);
                    ena = 1'b0;
                    repeat (2) @(negedge clk);
                end
            end
        join
        repeat (2) @(negedge clk);
        chk("sparse_drained", exp_q.size(), 0);
        chk("sparse_pulses", pulses - base_pulses, 60);
        chk("sparse_repeats", extra - base_extra, 0);
        chk("sparse_underrun", int'(underrun), 0);

        // Reset during the 4th repeat with two samples queued
        do_reset();
        push(-1000, 1'b1);
        push(1111, 1'b1);
        push(-1222, 1'b1);
        idle();
        for (int k = 0; k < FACTOR - 4; k++) void'(exp_q.pop_back());
        run_ena(4);
        do_reset();
        mark();
        run_ena(20);
        repeat (2) @(negedge clk);
        chk("mid_silent", pulses - base_pulses, 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_underrun", int'(underrun), 0);
        push(12'h2AA, 1'b1);
        idle();
        run_ena(10);
        repeat (2) @(negedge clk);
        chk("mid_new_pulses", pulses - base_pulses, 10);
        chk("mid_drained", exp_q.size(), 0);
        chk("mid_repeats", extra - base_extra, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
